// File: rtl/status_reg.sv
// Processor status register: accumulator, N/Z/C/V flags and an optional save stack.
// Define STATUS_STACK_EN to build the save stack; without it PUSH/POP are ignored and SP/ERR read 0.
module status_reg #(
  parameter int DEPTH = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] Y,
  input  logic       C,
  input  logic       V,
  input  logic       UPD,
  input  logic       LDACC,
  input  logic       SEC,
  input  logic       CLC,
  input  logic       PUSH,
  input  logic       POP,
  output logic [7:0] ACC,
  output logic       NF,
  output logic       ZF,
  output logic       CF,
  output logic       VF,
  output logic       CO,
  output logic [2:0] SP,
  output logic       ERR
);

  logic        do_pop;
  logic [11:0] pop_data;

`ifdef STATUS_STACK_EN
  localparam logic [2:0] DEPTH_W = 3'(DEPTH);

  // Entries are packed {acc, n, z, c, v}; sized to the full SP range so any SP indexes cleanly.
  logic [11:0] stk [0:7];
  logic        full, empty, do_push, misuse;
  logic [2:0]  sp_dec;

  always_comb begin
    full     = (SP == DEPTH_W);
    empty    = (SP == 3'd0);
    do_push  = PUSH & ~POP & ~full;
    do_pop   = POP & ~PUSH & ~empty;
    misuse   = (PUSH & POP) | (PUSH & full) | (POP & empty);
    sp_dec   = SP - 3'd1;
    pop_data = stk[sp_dec];
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      SP  <= 3'd0;
      ERR <= 1'b0;
    end else begin
      if (do_push) begin
        stk[SP] <= {ACC, NF, ZF, CF, VF};
        SP      <= SP + 3'd1;
      end else if (do_pop) begin
        SP <= sp_dec;
      end
      if (misuse) ERR <= 1'b1;
    end
  end
`else
  logic unused_stack_ctl;

  assign unused_stack_ctl = PUSH ^ POP;
  assign do_pop           = 1'b0;
  assign pop_data         = 12'h000;
  assign SP               = 3'd0;
  assign ERR              = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      ACC <= 8'h00;
      NF  <= 1'b0;
      ZF  <= 1'b0;
      CF  <= 1'b0;
      VF  <= 1'b0;
    end else if (do_pop) begin
      {ACC, NF, ZF, CF, VF} <= pop_data;
    end else begin
      if (LDACC) ACC <= Y;
      if (UPD) begin
        NF <= Y[7];
        ZF <= (Y == 8'h00);
        CF <= C;
        VF <= V;
      end else if (SEC & ~CLC) begin
        CF <= 1'b1;
      end else if (CLC & ~SEC) begin
        CF <= 1'b0;
      end
    end
  end

  assign CO = CF;

endmodule
